// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter that shares the single register-file write port between
// NUM_REQ write-back requesters. The granted request is registered and driven
// to the register file as a one-hot write enable plus data on the next cycle.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   req_i      per-requester write request (level)
//   addr_i     packed destination addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   data_i     packed write data, same packing as addr_i
//   gnt_o      one-hot grant, combinational, same cycle as the accepted request
//   stall_i    register file cannot take the presented write this cycle
//   wr_en_o    one-hot per-register write enable (registered)
//   wr_data_o  write data presented with wr_en_o (registered)
//   busy_o     a write is currently presented
//
// Optional build macro: REGFILE_WRITE_ARBITER_ZERO_DISCARD_EN
//   When defined, a granted write to address 0 consumes its round-robin turn
//   but is dropped instead of being presented to the register file.

module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    data_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  input  logic                             stall_i,
  output logic [NUM_REGS-1:0]              wr_en_o,
  output logic [DATA_WIDTH-1:0]            wr_data_o,
  output logic                             busy_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REGS-1:0]     wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                    found;
  logic [PTR_W-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    accept;
  logic                    discard;
  logic                    load;

  // Round-robin search: first requesting index at or above the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned j;
      j = 32'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found   = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  // Winner's payload.
  always_comb begin
    int unsigned base_a;
    int unsigned base_d;
    base_a   = 32'(win_idx) * ADDR_WIDTH;
    base_d   = 32'(win_idx) * DATA_WIDTH;
    win_addr = addr_i[base_a +: ADDR_WIDTH];
    win_data = data_i[base_d +: DATA_WIDTH];
  end

  // A held PRESENT write blocks new grants while stalled; reset forces no grant.
  assign accept = found & rst_ni & ((state_q == IDLE) | ~stall_i);

`ifdef REGFILE_WRITE_ARBITER_ZERO_DISCARD_EN
  assign discard = (win_addr == '0);
`else
  assign discard = 1'b0;
`endif

  assign load  = accept & ~discard;
  assign gnt_o = accept ? (NUM_REQ'(1) << win_idx) : '0;

  // Next-state, pointer and output-register logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;

    if (accept) begin
      if (win_idx == PTR_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                ptr_d = win_idx + PTR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = PRESENT;
          wr_en_d   = NUM_REGS'(1) << win_addr;
          wr_data_d = win_data;
        end
      end
      PRESENT: begin
        // The presented write retires on any unstalled cycle.
        if (!stall_i) begin
          if (load) begin
            state_d   = PRESENT;
            wr_en_d   = NUM_REGS'(1) << win_addr;
            wr_data_d = win_data;
          end else begin
            state_d = IDLE;
            wr_en_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q == PRESENT);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (pointer + presented write).

module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int NREG = 32;

`ifdef REGFILE_WRITE_ARBITER_ZERO_DISCARD_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [AW-1:0]        addr_a [NREQ];
  logic [DW-1:0]        data_a [NREQ];
  logic [NREQ*AW-1:0]   addr_bus;
  logic [NREQ*DW-1:0]   data_bus;
  logic [NREQ-1:0]      gnt;
  logic                 stall;
  logic [NREG-1:0]      wr_en;
  logic [DW-1:0]        wr_data;
  logic                 busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_ptr;
  bit          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [NREQ-1:0] exp_gnt;
  logic [NREQ-1:0] obs_gnt;

  regfile_write_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREG)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr_bus),
    .data_i(data_bus), .gnt_o(gnt), .stall_i(stall), .wr_en_o(wr_en),
    .wr_data_o(wr_data), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      addr_bus[k*AW +: AW] = addr_a[k];
      data_bus[k*DW +: DW] = data_a[k];
    end
  end

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  function automatic logic [NREG-1:0] model_wren();
    return m_valid ? onehot(m_addr) : '0;
  endfunction

  // One clock: sample grant at negedge, advance model at the edge, settle #1.
  task automatic tick();
    int  g;
    bit  acc;
    @(negedge clk);
    obs_gnt = gnt;
    acc = (req != 0) && (!m_valid || !stall);
    g = -1;
    exp_gnt = '0;
    if (acc) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (g < 0 && req[k]) g = k;
      end
      exp_gnt[g] = 1'b1;
    end
    @(posedge clk);
    if (acc) begin
      m_ptr = (g + 1) % NREQ;
      if (ZD && addr_a[g] == 0) m_valid = 1'b0;
      else begin
        m_valid = 1'b1;
        m_addr  = addr_a[g];
        m_data  = data_a[g];
      end
    end else if (m_valid && !stall) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin addr_a[k] = AW'(k + 1); data_a[k] = DW'(k); end
    model_reset();
    #1;
    n_checks++; if (wr_en !== '0) $display("FAIL reset_wren got %h want 0", wr_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (gnt !== '0) $display("FAIL reset_gnt got %b want 0", gnt); else n_pass++;
    n_checks++; if (wr_data !== '0) $display("FAIL reset_data got %h want 0", wr_data); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    req = 4'b0001; addr_a[0] = 5'd6; data_a[0] = 64'h77;
    tick();
    n_checks++; if (obs_gnt !== 4'b0001) $display("FAIL rst_pre_gnt got %b want 0001", obs_gnt); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", busy); else n_pass++;
    // asynchronous reset mid-cycle while PRESENT
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (wr_en !== '0) $display("FAIL async_rst_wren got %h want 0", wr_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (gnt !== '0) $display("FAIL async_rst_gnt got %b want 0", gnt); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (wr_en !== '0) $display("FAIL rst_hold_wren got %h want 0", wr_en); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (obs_gnt !== 4'b0001) $display("FAIL post_rst_gnt got %b want 0001", obs_gnt); else n_pass++;
    n_checks++; if (wr_en !== onehot(5'd6)) $display("FAIL post_rst_wren got %h want %h", wr_en, onehot(5'd6)); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg [5];
    logic [AW-1:0]   ea [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ea = '{5'd3, 5'd7, 5'd9, 5'd12, 5'd3};
    do_reset();
    addr_a = '{5'd3, 5'd7, 5'd9, 5'd12};
    for (int k = 0; k < NREQ; k++) data_a[k] = DW'(100 + k);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (obs_gnt !== eg[i]) $display("FAIL rr_gnt[%0d] got %b want %b", i, obs_gnt, eg[i]); else n_pass++;
      n_checks++; if (wr_en !== onehot(ea[i])) $display("FAIL rr_wren[%0d] got %h want %h", i, wr_en, onehot(ea[i])); else n_pass++;
      n_checks++; if (wr_data !== DW'(100 + (i % 4))) $display("FAIL rr_data[%0d] got %0d want %0d", i, wr_data, 100 + (i % 4)); else n_pass++;
    end
    req = '0; tick();
  endtask

  task automatic test_stall();
    do_reset();
    addr_a[0] = 5'd17; data_a[0] = 64'hA0A0;
    addr_a[1] = 5'd18; data_a[1] = 64'hB1B1;
    req = 4'b0011;
    tick();
    n_checks++; if (obs_gnt !== 4'b0001) $display("FAIL stall_first_gnt got %b want 0001", obs_gnt); else n_pass++;
    req = 4'b0010; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (obs_gnt !== '0) $display("FAIL stall_gnt[%0d] got %b want 0000", i, obs_gnt); else n_pass++;
      n_checks++; if (wr_en !== onehot(5'd17)) $display("FAIL stall_wren[%0d] got %h want %h", i, wr_en, onehot(5'd17)); else n_pass++;
      n_checks++; if (wr_data !== 64'hA0A0) $display("FAIL stall_data[%0d] got %h want a0a0", i, wr_data); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_checks++; if (obs_gnt !== 4'b0010) $display("FAIL unstall_gnt got %b want 0010", obs_gnt); else n_pass++;
    n_checks++; if (wr_en !== onehot(5'd18)) $display("FAIL unstall_wren got %h want %h", wr_en, onehot(5'd18)); else n_pass++;
    req = '0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL stall_idle_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    addr_a[2] = 5'd10;
    req = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      data_a[2] = DW'(i);
      tick();
      n_checks++; if (obs_gnt !== 4'b0100) $display("FAIL b2b_gnt[%0d] got %b want 0100", i, obs_gnt); else n_pass++;
      n_checks++; if (wr_data !== DW'(i)) $display("FAIL b2b_data[%0d] got %0d want %0d", i, wr_data, i); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy[%0d] got %b want 1", i, busy); else n_pass++;
    end
    req = '0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_fall_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_en !== '0) $display("FAIL b2b_fall_wren got %h want 0", wr_en); else n_pass++;
  endtask

  task automatic test_same_addr();
    do_reset();
    addr_a[0] = 5'd20; data_a[0] = 64'h1;
    req = 4'b0001;
    tick();  // pointer now 1
    req = 4'b0110;
    addr_a[1] = 5'd5; data_a[1] = 64'hAA;
    addr_a[2] = 5'd5; data_a[2] = 64'hBB;
    tick();
    n_checks++; if (obs_gnt !== 4'b0010) $display("FAIL same_gnt1 got %b want 0010", obs_gnt); else n_pass++;
    n_checks++; if (wr_en !== onehot(5'd5) || wr_data !== 64'hAA) $display("FAIL same_w1 got %h/%h want %h/aa", wr_en, wr_data, onehot(5'd5)); else n_pass++;
    req = 4'b0100;
    tick();
    n_checks++; if (obs_gnt !== 4'b0100) $display("FAIL same_gnt2 got %b want 0100", obs_gnt); else n_pass++;
    n_checks++; if (wr_en !== onehot(5'd5) || wr_data !== 64'hBB) $display("FAIL same_w2 got %h/%h want %h/bb", wr_en, wr_data, onehot(5'd5)); else n_pass++;
    req = '0; tick();
  endtask

  task automatic test_zero_reg();
    logic [NREG-1:0] exp_first;
    do_reset();
    addr_a[0] = 5'd0; data_a[0] = 64'hC0;
    addr_a[1] = 5'd4; data_a[1] = 64'hC4;
    req = 4'b0011;
    tick();
    exp_first = ZD ? '0 : onehot(5'd0);
    n_checks++; if (obs_gnt !== 4'b0001) $display("FAIL zero_gnt1 got %b want 0001", obs_gnt); else n_pass++;
    n_checks++; if (wr_en !== exp_first) $display("FAIL zero_wren1 got %h want %h", wr_en, exp_first); else n_pass++;
    n_checks++; if (busy !== !ZD) $display("FAIL zero_busy1 got %b want %b", busy, !ZD); else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++; if (obs_gnt !== 4'b0010) $display("FAIL zero_gnt2 got %b want 0010", obs_gnt); else n_pass++;
    n_checks++; if (wr_en !== onehot(5'd4)) $display("FAIL zero_wren2 got %h want %h", wr_en, onehot(5'd4)); else n_pass++;
    req = '0; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = NREQ'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NREQ; k++) begin
        addr_a[k] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        data_a[k] = {$urandom, $urandom};
      end
      tick();
      n_checks++; if (obs_gnt !== exp_gnt) $display("FAIL rand_gnt[%0d] got %b want %b", c, obs_gnt, exp_gnt); else n_pass++;
      n_checks++; if (wr_en !== model_wren()) $display("FAIL rand_wren[%0d] got %h want %h", c, wr_en, model_wren()); else n_pass++;
      n_checks++; if (busy !== m_valid) $display("FAIL rand_busy[%0d] got %b want %b", c, busy, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (wr_data !== m_data) $display("FAIL rand_data[%0d] got %h want %h", c, wr_data, m_data); else n_pass++;
      end
    end
    req = '0; stall = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_back_to_back();
    test_same_addr();
    test_zero_reg();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against any unexpected hang.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
